// File: rtl/isa_pkg.sv
// Shared ISA definitions for the memory-access stage: opcodes, access sizes, FSM states, decode helpers.
package isa_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    typedef struct packed {
        logic  is_mem;
        logic  is_load;
        logic  is_signed;
        size_e size;
    } dec_t;

    // Fields carried unchanged from EX/MA to MA/WB
    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] alu;
        logic        flag;
        logic [31:0] npc;
    } pt_t;

    // Classify an opcode as load/store and its access width
    function automatic dec_t decode(input logic [5:0] op);
        dec_t d;
        d = '{is_mem: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: WORD};
        case (op)
            OP_LB:   d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: BYTE};
            OP_LH:   d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b1, size: HALF};
            OP_LW:   d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: WORD};
            OP_LBU:  d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: BYTE};
            OP_LHU:  d = '{is_mem: 1'b1, is_load: 1'b1, is_signed: 1'b0, size: HALF};
            OP_SB:   d = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: BYTE};
            OP_SH:   d = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: HALF};
            OP_SW:   d = '{is_mem: 1'b1, is_load: 1'b0, is_signed: 1'b0, size: WORD};
            default: d = '{is_mem: 1'b0, is_load: 1'b0, is_signed: 1'b0, size: WORD};
        endcase
        return d;
    endfunction

    // Natural alignment check; byte accesses can never be misaligned
    function automatic logic misaligned(input size_e size, input logic [1:0] a);
        logic m;
        case (size)
            HALF:    m = a[0];
            WORD:    m = (a != 2'b00);
            default: m = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ma_lane_fmt.sv
// Little-endian byte-lane steering: store enables/data and load extraction/extension.
module ma_lane_fmt
    import isa_pkg::*;
(
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [1:0]  a_i,
    input  logic [31:0] rt_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // Shift the addressed lane down to bit 0 and build store/load views
    always_comb begin
        byte_sh = rdata_i >> {a_i, 3'b000};
        half_sh = rdata_i >> {a_i[1], 4'b0000};
        be_o    = 4'b1111;
        wdata_o = rt_i;
        ldata_o = rdata_i;
        case (size_i)
            BYTE: begin
                be_o    = 4'b0001 << a_i;
                wdata_o = {4{rt_i[7:0]}};
                ldata_o = {{24{signed_i & byte_sh[7]}}, byte_sh[7:0]};
            end
            HALF: begin
                be_o    = a_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{rt_i[15:0]}};
                ldata_o = {{16{signed_i & half_sh[15]}}, half_sh[15:0]};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = rt_i;
                ldata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: issues load/store over a req/ack port, stalls upstream while outstanding.
module ma_stage
    import isa_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] IRin,
    input  logic [31:0] ALUOutin,
    input  logic [31:0] Rtin,
    input  logic        Flagin,
    input  logic [31:0] NPCin,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [31:0] MemDataout,
    output logic [31:0] ALUOutout,
    output logic [31:0] IRout,
    output logic        Flagout,
    output logic [31:0] NPCout,
    output logic        addr_err,
    output logic        bus_err
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [31:0]     mem_addr_q, mem_addr_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    pt_t             pt_lat_q, pt_lat_d;
    pt_t             pt_out_q, pt_out_d;
    logic [31:0]     memdata_q, memdata_d;
    logic            wb_valid_q, wb_valid_d;
    logic            addr_err_q, addr_err_d;
    logic            bus_err_q, bus_err_d;

    pt_t         pt_in;
    dec_t        dec_in, dec_lat;
    size_e       fmt_size;
    logic        fmt_signed;
    logic [1:0]  fmt_a;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_ldata;

    assign pt_in = '{ir: IRin, alu: ALUOutin, flag: Flagin, npc: NPCin};

    // Lane formatter sees the live instruction in IDLE and the latched one in REQ
    always_comb begin
        dec_in     = decode(IRin[31:26]);
        dec_lat    = decode(pt_lat_q.ir[31:26]);
        fmt_size   = (state_q == REQ) ? dec_lat.size      : dec_in.size;
        fmt_signed = (state_q == REQ) ? dec_lat.is_signed : dec_in.is_signed;
        fmt_a      = (state_q == REQ) ? pt_lat_q.alu[1:0] : ALUOutin[1:0];
    end

    ma_lane_fmt u_lane_fmt (
        .size_i   (fmt_size),
        .signed_i (fmt_signed),
        .a_i      (fmt_a),
        .rt_i     (Rtin),
        .rdata_i  (mem_rdata),
        .be_o     (fmt_be),
        .wdata_o  (fmt_wdata),
        .ldata_o  (fmt_ldata)
    );

    // Next-state, request and write-back output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        pt_lat_d    = pt_lat_q;
        pt_out_d    = pt_out_q;
        memdata_d   = memdata_q;
        wb_valid_d  = 1'b0;
        addr_err_d  = 1'b0;
        bus_err_d   = 1'b0;
        stall       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!dec_in.is_mem) begin
                        wb_valid_d = 1'b1;
                        pt_out_d   = pt_in;
                        memdata_d  = 32'h0;
                    end else if (misaligned(dec_in.size, ALUOutin[1:0])) begin
                        addr_err_d = 1'b1;
                        pt_out_d   = pt_in;
                        memdata_d  = 32'h0;
                    end else begin
                        stall       = 1'b1;
                        state_d     = REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !dec_in.is_load;
                        mem_addr_d  = {ALUOutin[31:2], 2'b00};
                        mem_be_d    = fmt_be;
                        mem_wdata_d = fmt_wdata;
                        pt_lat_d    = pt_in;
                    end
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    pt_out_d   = pt_lat_q;
                    memdata_d  = (dec_lat.is_mem && dec_lat.is_load) ? fmt_ldata : 32'h0;
                end else if (cnt_q == TO_LAST) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                end else begin
                    stall = 1'b1;
                    cnt_d = TO_W'(cnt_q + 1'b1);
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            pt_lat_q    <= '0;
            pt_out_q    <= '0;
            memdata_q   <= 32'h0;
            wb_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            pt_lat_q    <= pt_lat_d;
            pt_out_q    <= pt_out_d;
            memdata_q   <= memdata_d;
            wb_valid_q  <= wb_valid_d;
            addr_err_q  <= addr_err_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign MemDataout = memdata_q;
    assign ALUOutout  = pt_out_q.alu;
    assign IRout      = pt_out_q.ir;
    assign Flagout    = pt_out_q.flag;
    assign NPCout     = pt_out_q.npc;
    assign addr_err   = addr_err_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_ma_stage.sv
// Self-checking bench for ma_stage: vector table, scoreboard queue and hand-written corner sequences.
module tb_ma_stage;

    localparam logic [2:0] K_WB = 3'b100;
    localparam logic [2:0] K_AE = 3'b010;
    localparam logic [2:0] K_BE = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] IRin, ALUOutin, Rtin, NPCin;
    logic        Flagin;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid, Flagout, addr_err, bus_err;
    logic [31:0] MemDataout, ALUOutout, IRout, NPCout;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [31:0] ir;
        logic        flag;
        logic [31:0] npc;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          ack_dly;
        logic [2:0]  kind;
        logic [31:0] mem;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req;
        int          stl;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[14];

    ma_stage #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .IRin       (IRin),
        .ALUOutin   (ALUOutin),
        .Rtin       (Rtin),
        .Flagin     (Flagin),
        .NPCin      (NPCin),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .MemDataout (MemDataout),
        .ALUOutout  (ALUOutout),
        .IRout      (IRout),
        .Flagout    (Flagout),
        .NPCout     (NPCout),
        .addr_err   (addr_err),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                                input logic [31:0] rdata, input int ack_dly, input logic [2:0] kind,
                                input logic [31:0] mem, input logic [3:0] be, input logic [31:0] wdata,
                                input int req, input int stl);
        vec_t v;
        v.op = op; v.addr = addr; v.rt = rt; v.rdata = rdata; v.ack_dly = ack_dly;
        v.kind = kind; v.mem = mem; v.be = be; v.wdata = wdata; v.req = req; v.stl = stl;
        return v;
    endfunction

    // Scoreboard: every result pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && (wb_valid || addr_err || bus_err)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({wb_valid, addr_err, bus_err}), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", 32'({wb_valid, addr_err, bus_err}), 32'(e.kind));
                if (e.kind == K_WB) begin
                    chk("MemDataout", MemDataout, e.mem);
                    chk("Flagout", 32'(Flagout), 32'(e.flag));
                    chk("NPCout", NPCout, e.npc);
                end
                if (e.kind != K_BE) begin
                    chk("ALUOutout", ALUOutout, e.alu);
                    chk("IRout", IRout, e.ir);
                end
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        int   req_cyc, stall_cyc, guard;
        bit   accepted;
        bit   is_store;
        is_store = v.op inside {6'h28, 6'h29, 6'h2B};
        e.kind = v.kind; e.mem = v.mem; e.alu = v.addr;
        e.ir   = {v.op, 26'(idx * 32'h1357)};
        e.flag = idx[0];
        e.npc  = 32'h4000 + 32'(idx * 4);
        exp_q.push_back(e);
        @(negedge clk); #2;
        in_valid = 1'b1; IRin = e.ir; ALUOutin = v.addr; Rtin = v.rt; Flagin = e.flag; NPCin = e.npc;
        req_cyc = 0; stall_cyc = 0; guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            if (mem_req) begin
                chk($sformatf("v%0d_addr", idx), mem_addr, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d_be", idx), 32'(mem_be), 32'(v.be));
                chk($sformatf("v%0d_we", idx), 32'(mem_we), 32'(is_store));
                if (is_store) chk($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
                if (v.ack_dly >= 0 && req_cyc == v.ack_dly) begin
                    mem_ack = 1'b1; mem_rdata = v.rdata;
                end
                req_cyc++;
            end
            #1;
            if (stall) stall_cyc++;
            accepted = in_valid && !stall;
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            if (accepted) in_valid = 1'b0;
            @(negedge clk); #2;
            guard++;
        end
        chk($sformatf("v%0d_done", idx), 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        chk($sformatf("v%0d_req_cycles", idx), 32'(req_cyc), 32'(v.req));
        chk($sformatf("v%0d_stall_cycles", idx), 32'(stall_cyc), 32'(v.stl));
        in_valid = 1'b0;
    endtask

    // A stray ack after an abort must not produce any result
    task automatic late_ack();
        @(negedge clk); #2;
        mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk); #2;
        chk("late_ack_wb", 32'(wb_valid), 32'h0);
        chk("late_ack_req", 32'(mem_req), 32'h0);
        chk("late_ack_stall", 32'(stall), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic pulses;
        int   req, guard;
        rst = 1'b1; in_valid = 1'b0; IRin = '0; ALUOutin = '0; Rtin = '0; Flagin = 1'b0; NPCin = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        vecs[0]  = mk(6'h00, 32'h0000_1234, 32'h0, 32'h0, -1, K_WB, 32'h0, 4'h0, 32'h0, 0, 0);
        vecs[1]  = mk(6'h20, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 3, K_WB, 32'hFFFF_FF80, 4'b1000, 32'h0, 4, 4);
        vecs[2]  = mk(6'h25, 32'h0000_0102, 32'h0, 32'hBEEF_1234, 0, K_WB, 32'h0000_BEEF, 4'b1100, 32'h0, 1, 1);
        vecs[3]  = mk(6'h29, 32'h0000_0202, 32'hAAAA_5566, 32'h0, 1, K_WB, 32'h0, 4'b1100, 32'h5566_5566, 2, 2);
        vecs[4]  = mk(6'h23, 32'h0000_0301, 32'h0, 32'h0, -1, K_AE, 32'h0, 4'h0, 32'h0, 0, 0);
        vecs[5]  = mk(6'h2B, 32'h0000_0400, 32'h1122_3344, 32'h0, -1, K_BE, 32'h0, 4'b1111, 32'h1122_3344, 16, 16);
        vecs[6]  = mk(6'h21, 32'h0000_0106, 32'h0, 32'h8001_7FFF, 2, K_WB, 32'hFFFF_8001, 4'b1100, 32'h0, 3, 3);
        vecs[7]  = mk(6'h24, 32'h0000_0502, 32'h0, 32'h12AB_3456, 1, K_WB, 32'h0000_00AB, 4'b0100, 32'h0, 2, 2);
        vecs[8]  = mk(6'h28, 32'h0000_0503, 32'h1234_5678, 32'h0, 0, K_WB, 32'h0, 4'b1000, 32'h7878_7878, 1, 1);
        vecs[9]  = mk(6'h21, 32'h0000_0101, 32'h0, 32'h0, -1, K_AE, 32'h0, 4'h0, 32'h0, 0, 0);
        vecs[10] = mk(6'h23, 32'h0000_0700, 32'h0, 32'hDEAD_BEEF, 2, K_WB, 32'hDEAD_BEEF, 4'b1111, 32'h0, 3, 3);
        vecs[11] = mk(6'h2B, 32'h0000_0800, 32'hCAFE_F00D, 32'h0, 0, K_WB, 32'h0, 4'b1111, 32'hCAFE_F00D, 1, 1);
        vecs[12] = mk(6'h20, 32'h0000_0000, 32'h0, 32'h0000_007F, 0, K_WB, 32'h0000_007F, 4'b0001, 32'h0, 1, 1);
        vecs[13] = mk(6'h0D, 32'h0000_FACE, 32'h0, 32'h0, -1, K_WB, 32'h0, 4'h0, 32'h0, 0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_MemDataout", MemDataout, 32'h0);
        chk("rst_ALUOutout", ALUOutout, 32'h0);
        chk("rst_errs", 32'({addr_err, bus_err}), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_vec(i, vecs[i]);
            if (vecs[i].kind == K_BE) late_ack();
        end

        // Idle cycles keep the last write-back fields
        repeat (3) @(negedge clk);
        #2;
        chk("idle_wb_valid", 32'(wb_valid), 32'h0);
        chk("idle_hold_alu", ALUOutout, 32'h0000_FACE);
        chk("idle_hold_npc", NPCout, 32'h4000 + 32'(13 * 4));

        // Reset during the fifth REQ cycle aborts silently
        @(negedge clk); #2;
        in_valid = 1'b1; IRin = {6'h2B, 26'h0}; ALUOutin = 32'h900; Rtin = 32'h1; Flagin = 1'b0; NPCin = 32'h0;
        req = 0; guard = 0;
        while (req < 5 && guard < 30) begin
            if (mem_req) req++;
            if (req < 5) begin
                @(posedge clk); #1;
                @(negedge clk); #2;
            end
            guard++;
        end
        chk("rstreq_reached", 32'(req), 32'h5);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstreq_mem_req", 32'(mem_req), 32'h0);
        chk("rstreq_stall", 32'(stall), 32'h0);
        @(negedge clk); #2;
        rst = 1'b0;
        pulses = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); #2;
            pulses = pulses | wb_valid | addr_err | bus_err | mem_req;
        end
        chk("rstreq_no_pulses", 32'(pulses), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
